// File: rtl/count_stepper_pkg.sv
// Shared types and helpers for the count_stepper pulse driver.
// Holds the FSM state encoding, default sizing constants and the wrap-distance function.
package count_stepper_pkg;

    localparam int MODULUS_DEFAULT = 5;
    localparam int CW_DEFAULT      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Forward distance from current to target on a mod-`modulus` ring; both inputs must be < modulus.
    function automatic int unsigned mod_dist(input int unsigned target,
                                             input int unsigned current,
                                             input int unsigned modulus);
        int unsigned sum;
        sum = target + modulus - current;
        return (sum >= modulus) ? sum - modulus : sum;
    endfunction

endpackage

// File: rtl/count_stepper_if.sv
// Request/step bundle between a requester (master) and count_stepper (slave).
interface count_stepper_if #(
    parameter int CW = count_stepper_pkg::CW_DEFAULT
);
    logic          req_valid;
    logic [CW-1:0] req_target;
    logic          req_ready;
    logic          step;
    logic [CW-1:0] track_count;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_target,
        input  req_ready, step, track_count, busy, done, err
    );

    modport slave (
        input  req_valid, req_target,
        output req_ready, step, track_count, busy, done, err
    );
endinterface

// File: rtl/count_stepper_gap_timer.sv
// Down-counter that times the idle cycles between step pulses.
// Loaded with GAP while the FSM is pulsing; o_expired marks the final idle cycle.
module gap_timer #(
    parameter int GAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_tick,
    output logic o_expired
);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [GW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= GW'(GAP);
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count <= GW'(1));

endmodule

// File: rtl/count_stepper.sv
// Emits single-cycle step pulses that walk a downstream mod-MODULUS counter to a requested target,
// keeping a shadow copy of that counter in track_count.
module count_stepper
    import count_stepper_pkg::*;
#(
    parameter int MODULUS = MODULUS_DEFAULT,
    parameter int GAP     = 1,
    parameter int CW      = CW_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    count_stepper_if.slave bus
);

    state_t        r_state;
    logic [CW-1:0] r_remaining;
    logic [CW-1:0] r_track;
    logic          r_step;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_ready;

    logic          w_accept;
    logic          w_target_bad;
    logic [CW-1:0] w_dist;
    logic [CW-1:0] w_track_next;
    logic          w_gap_load;
    logic          w_gap_tick;
    logic          w_gap_expired;

    assign w_accept     = bus.req_valid & r_ready;
    assign w_target_bad = ({1'b0, bus.req_target} >= (CW + 1)'(MODULUS));
    assign w_dist       = CW'(mod_dist(int'(bus.req_target), int'(r_track), MODULUS));
    assign w_track_next = (r_track == CW'(MODULUS - 1)) ? '0 : r_track + 1'b1;
    assign w_gap_load   = (r_state == ST_PULSE);
    assign w_gap_tick   = (r_state == ST_GAP);

    generate
        if (GAP > 0) begin : g_gap
            gap_timer #(.GAP(GAP)) u_gap_timer (
                .clk       (clk),
                .reset     (reset),
                .i_load    (w_gap_load),
                .i_tick    (w_gap_tick),
                .o_expired (w_gap_expired)
            );
        end else begin : g_no_gap
            assign w_gap_expired = 1'b1;
        end
    endgenerate

    // Outputs are registered: each one is set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_track     <= '0;
            r_step      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        if (w_target_bad) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_dist == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_PULSE;
                            r_step      <= 1'b1;
                            r_remaining <= w_dist;
                        end
                    end
                end
                ST_PULSE: begin
                    r_track     <= w_track_next;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CW'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (GAP > 0) begin
                        r_state <= ST_GAP;
                    end else begin
                        r_step <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_expired) begin
                        r_state <= ST_PULSE;
                        r_step  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.step        = r_step;
    assign bus.track_count = r_track;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_count_stepper.sv
// Directed bench for count_stepper: one GAP=1 and one GAP=0 instance, each beside a mod-5 counter model.
module tb_count_stepper;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_target;
    logic       sel_g0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_stepper_if #(.CW(3)) bus_g1 ();
    count_stepper_if #(.CW(3)) bus_g0 ();

    assign bus_g1.req_valid  = req_valid & ~sel_g0;
    assign bus_g1.req_target = req_target;
    assign bus_g0.req_valid  = req_valid & sel_g0;
    assign bus_g0.req_target = req_target;

    count_stepper #(.MODULUS(5), .GAP(1), .CW(3)) dut_g1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_g1)
    );

    count_stepper #(.MODULUS(5), .GAP(0), .CW(3)) dut_g0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_g0)
    );

    // Downstream counters driven by each step output.
    logic [2:0] cnt_g1, cnt_g0;
    always @(posedge clk) begin
        if (reset) cnt_g1 <= 3'd0;
        else if (bus_g1.step) cnt_g1 <= (cnt_g1 == 3'd4) ? 3'd0 : cnt_g1 + 3'd1;
    end
    always @(posedge clk) begin
        if (reset) cnt_g0 <= 3'd0;
        else if (bus_g0.step) cnt_g0 <= (cnt_g0 == 3'd4) ? 3'd0 : cnt_g0 + 3'd1;
    end

    logic       step_o, busy_o, done_o, err_o, ready_o;
    logic [2:0] track_o, cnt_o;
    assign step_o  = sel_g0 ? bus_g0.step        : bus_g1.step;
    assign busy_o  = sel_g0 ? bus_g0.busy        : bus_g1.busy;
    assign done_o  = sel_g0 ? bus_g0.done        : bus_g1.done;
    assign err_o   = sel_g0 ? bus_g0.err         : bus_g1.err;
    assign ready_o = sel_g0 ? bus_g0.req_ready   : bus_g1.req_ready;
    assign track_o = sel_g0 ? bus_g0.track_count : bus_g1.track_count;
    assign cnt_o   = sel_g0 ? cnt_g0             : cnt_g1;

    // Issues one request and records step cycles (bit k = cycle T+k), the done cycle and err.
    // Optionally raises a second request in cycle inj_cyc. Returns in the IDLE cycle after done.
    task automatic issue(input logic [2:0] tgt, input int inj_cyc, input logic [2:0] inj_tgt,
                         output int mask, output int done_cyc, output logic err_at_done,
                         output logic overlap, output logic ready_inj);
        mask        = 0;
        done_cyc    = -1;
        err_at_done = 1'b0;
        overlap     = 1'b0;
        ready_inj   = 1'b1;
        req_valid   = 1'b1;
        req_target  = tgt;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_target = tgt ^ 3'b011;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == inj_cyc) begin
                req_valid  = 1'b1;
                req_target = inj_tgt;
                ready_inj  = ready_o;
            end else begin
                req_valid = 1'b0;
            end
            if (step_o) mask |= (1 << cyc);
            if (step_o && done_o) overlap = 1'b1;
            if (done_o) begin
                done_cyc    = cyc;
                err_at_done = err_o;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_target = 3'd0; sel_g0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", step_o); end
        n_checks++; if (track_o !== 3'd0) begin n_fail++; $display("FAIL reset_track: got %0d expected 0", track_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b expected 00", done_o, err_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        sel_g0 = 1'b1; #1;
        n_checks++; if (ready_o !== 1'b1 || track_o !== 3'd0) begin n_fail++; $display("FAIL reset_g0: got ready=%b track=%0d expected ready=1 track=0", ready_o, track_o); end
        sel_g0 = 1'b0; #1;
    endtask

    task automatic test_basic();
        int m, d; logic e, ov, ri;
        issue(3'd3, 0, 3'd0, m, d, e, ov, ri);
        n_checks++; if (m !== 32'h2A) begin n_fail++; $display("FAIL basic_steps: got %0h expected 2a", m); end
        n_checks++; if (d !== 6) begin n_fail++; $display("FAIL basic_done: got %0d expected 6", d); end
        n_checks++; if (e !== 1'b0 || ov !== 1'b0) begin n_fail++; $display("FAIL basic_err_overlap: got %b%b expected 00", e, ov); end
        n_checks++; if (track_o !== 3'd3 || cnt_o !== 3'd3) begin n_fail++; $display("FAIL basic_track: got %0d/%0d expected 3/3", track_o, cnt_o); end
    endtask

    task automatic test_wrap();
        int m, d; logic e, ov, ri;
        issue(3'd1, 0, 3'd0, m, d, e, ov, ri);
        n_checks++; if (m !== 32'h2A) begin n_fail++; $display("FAIL wrap_steps: got %0h expected 2a", m); end
        n_checks++; if (d !== 6) begin n_fail++; $display("FAIL wrap_done: got %0d expected 6", d); end
        n_checks++; if (track_o !== 3'd1 || cnt_o !== 3'd1) begin n_fail++; $display("FAIL wrap_track: got %0d/%0d expected 1/1", track_o, cnt_o); end
    endtask

    task automatic test_equal();
        int m, d; logic e, ov, ri;
        issue(3'd1, 0, 3'd0, m, d, e, ov, ri);
        n_checks++; if (m !== 0) begin n_fail++; $display("FAIL equal_steps: got %0h expected 0", m); end
        n_checks++; if (d !== 1 || e !== 1'b0) begin n_fail++; $display("FAIL equal_done: got cyc=%0d err=%b expected cyc=1 err=0", d, e); end
        n_checks++; if (track_o !== 3'd1) begin n_fail++; $display("FAIL equal_track: got %0d expected 1", track_o); end
    endtask

    task automatic test_invalid();
        int m, d; logic e, ov, ri;
        issue(3'd6, 0, 3'd0, m, d, e, ov, ri);
        n_checks++; if (m !== 0) begin n_fail++; $display("FAIL invalid_steps: got %0h expected 0", m); end
        n_checks++; if (d !== 1 || e !== 1'b1) begin n_fail++; $display("FAIL invalid_done: got cyc=%0d err=%b expected cyc=1 err=1", d, e); end
        n_checks++; if (track_o !== 3'd1 || cnt_o !== 3'd1) begin n_fail++; $display("FAIL invalid_track: got %0d/%0d expected 1/1", track_o, cnt_o); end
        n_checks++; if (err_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL invalid_after: got err=%b ready=%b expected err=0 ready=1", err_o, ready_o); end
    endtask

    task automatic test_gap0_ignore();
        int m, d; logic e, ov, ri;
        sel_g0 = 1'b1; #1;
        issue(3'd4, 2, 3'd2, m, d, e, ov, ri);
        n_checks++; if (m !== 32'h1E) begin n_fail++; $display("FAIL gap0_steps: got %0h expected 1e", m); end
        n_checks++; if (d !== 5 || ov !== 1'b0) begin n_fail++; $display("FAIL gap0_done: got cyc=%0d overlap=%b expected cyc=5 overlap=0", d, ov); end
        n_checks++; if (ri !== 1'b0) begin n_fail++; $display("FAIL gap0_ready_busy: got %b expected 0", ri); end
        n_checks++; if (track_o !== 3'd4 || cnt_o !== 3'd4 || busy_o !== 1'b0) begin n_fail++; $display("FAIL gap0_track: got %0d/%0d busy=%b expected 4/4 busy=0", track_o, cnt_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        int m, d; logic e, ov, ri;
        issue(3'd1, 0, 3'd0, m, d, e, ov, ri);
        n_checks++; if (m !== 32'h6 || d !== 3) begin n_fail++; $display("FAIL b2b_first: got mask=%0h cyc=%0d expected mask=6 cyc=3", m, d); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", ready_o); end
        issue(3'd0, 0, 3'd0, m, d, e, ov, ri);
        n_checks++; if (m !== 32'h1E || d !== 5) begin n_fail++; $display("FAIL b2b_second: got mask=%0h cyc=%0d expected mask=1e cyc=5", m, d); end
        n_checks++; if (track_o !== 3'd0 || cnt_o !== 3'd0) begin n_fail++; $display("FAIL b2b_track: got %0d/%0d expected 0/0", track_o, cnt_o); end
        sel_g0 = 1'b0; #1;
    endtask

    task automatic test_reset_mid();
        logic activity;
        req_valid = 1'b1; req_target = 3'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (step_o !== 1'b1) begin n_fail++; $display("FAIL mid_first_step: got %b expected 1", step_o); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (step_o !== 1'b1 || track_o !== 3'd2) begin n_fail++; $display("FAIL mid_second_step: got step=%b track=%0d expected step=1 track=2", step_o, track_o); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (step_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL mid_step_done: got %b%b expected 00", step_o, done_o); end
        n_checks++; if (track_o !== 3'd0 || cnt_o !== 3'd0) begin n_fail++; $display("FAIL mid_track: got %0d/%0d expected 0/0", track_o, cnt_o); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got ready=%b busy=%b expected ready=1 busy=0", ready_o, busy_o); end
        activity = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (step_o || done_o) activity = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (activity !== 1'b0 || track_o !== 3'd0) begin n_fail++; $display("FAIL mid_quiet: got activity=%b track=%0d expected 0/0", activity, track_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_equal();
        test_invalid();
        test_gap0_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
